ctrl_mem: RTL and testbench
===========================

// Module: ctrl_mem
// PURPOSE
//  Memory-stage control for the 16-bit Thumb pipeline; consumes the instruction word handed on by EX.
//  Decodes loads/stores and drives the data-memory req/ack handshake, sequencing LDM/STM/PUSH/POP one register per transfer.
//  Raises o_stall while an access is outstanding; this freezes IF..EX.
//  Registers the instruction into the WB-stage IR.
// PARAMETERS
//  TIMEOUT_CYCLES  0   cycles without ack before the access is aborted; 0 = never abort
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  i_ir_mem       in   16  instruction in MEM stage; held stable by upstream while o_stall=1
//  i_stall        in   1   external pipeline stall, not caused by this block
//  i_dmem_ack     in   1   data memory completes the current transfer this cycle
//  o_dmem_req     out  1   access request, held until ack
//  o_dmem_we      out  1   1 = store
//  o_dmem_size    out  2   00 byte, 01 half, 10 word
//  o_dmem_sext    out  1   load result is sign-extended (LDRSB/LDRSH)
//  o_xfer_reg     out  4   register read (store) or written (load) by the current transfer
//  o_xfer_ofs     out  4   word offset of the current transfer from the list base address
//  o_xfer_cnt     out  4   number of registers in the list (popcount incl. LR/PC); 1 for single ops
//  o_stall        out  1   MEM stage busy; the pipeline must hold
//  o_bus_fault    out  1   one-cycle pulse when an access times out
//  o_ir_wb        out  16  instruction in WB stage
// BEHAVIOUR
//  Reset: state IDLE, count 0, timer 0, o_ir_wb=0, o_bus_fault=0. Request outputs are combinational and read 0 during and after reset.
//  Decode (i_ir_mem):
//   - 0101 ooo: register offset. ooo = STR, STRH, STRB, LDRSB, LDR, LDRH, LDRB, LDRSH.
//   - 0110/0111/1000 L: imm5 word/byte/half.
//   - 1001 L: SP-relative word. 01001: PC-relative LDR.
//   - 1011010M: PUSH, with M adding LR. 1011110P: POP, with P adding PC.
//   - 11000/11001: STM/LDM.
//   - Anything else is a non-memory op.
//  o_xfer_reg, single ops: Rt = ir[2:0]; SP-relative and PC-relative use ir[10:8].
//  o_xfer_reg, list ops: registers ascending from r0, then LR (14) for PUSH or PC (15) for POP.
//  Sizes and store/load direction follow the encoding above.
//  State machine:
//   - IDLE: memory op present and i_stall=0 -> req=1.
//     - With ack in the same cycle: a single op completes with no stall; a list op with cnt=1 also completes.
//     - Otherwise go to ACCESS (single op) or LIST (list op).
//   - ACCESS: req held; on ack -> IDLE.
//   - LIST: each ack does count++ and advances to the next set bit; o_xfer_ofs = count.
//     The ack on transfer cnt-1 -> IDLE.
//  o_stall = req & ~(ack on final transfer). It is combinational, so a zero-wait memory causes no stall.
//  o_ir_wb update rule:
//   - Loaded from i_ir_mem at an edge where o_stall=0 and i_stall=0.
//   - Loaded with NOP 0xBF00 at an edge where o_stall=1 (bubble into WB).
//   - Held at an edge where only i_stall=1.
//  Empty register list: treated as 0 transfers. No req and no stall; passes through like a non-memory op.
//  Ack while req=0: ignored.
//  i_stall=1 in IDLE: no new access starts.
//  i_stall=1 during ACCESS/LIST: the transfer in progress still completes; the next transfer is not issued until i_stall drops.
//  Timeout (TIMEOUT_CYCLES>0):
//   - The timer counts cycles with req=1 and no ack, and clears on ack.
//   - When it reaches TIMEOUT_CYCLES: pulse o_bus_fault, drop req, go to IDLE, bubble WB (the instruction is discarded).
//  Reset mid-access: req drops at the first reset cycle; state, count and timer clear.
// STRUCTURE
//  Package ctrl_pkg holds:
//   - typedef mem_size_t (BYTE/HALF/WORD)
//   - enum mem_state_t {IDLE, ACCESS, LIST}
//   - NOP_THUMB = 16'hBF00
//   - opcode-field masks
//  Sub-module mem_decode: combinational decode of i_ir_mem into is_mem, is_list, we, size, sext, rt, rlist[9:0].
//  The state machine, counter, priority encoder and timer live in ctrl_mem.
// TESTING
//  - LDR r3,[r1,#4] (0x684B), ack after 2 cycles -> req=1, we=0, size=10, reg=3; o_stall=1 for 2 cycles; ir_wb = 0xBF00, 0xBF00, then 0x684B.
//  - STRB r2,[r0,r1] (0x5442), ack in the same cycle -> req=1, we=1, size=00 for 1 cycle; o_stall=0; ir_wb=0x5442 next edge.
//  - PUSH {r0,r4,LR} (0xB511), zero wait -> reg=0,4,14 with ofs=0,1,2; cnt=3; o_stall high for 2 cycles.
//  - LDM r0!,{} (0xC800) and ADDS (0x1C08) -> no req, no stall; ir_wb follows the input each cycle.
//  - TIMEOUT_CYCLES=4, LDRSH with no ack -> o_bus_fault pulses in cycle 4; req drops; IDLE; ir_wb=0xBF00.
//  - POP {r1,PC} (0xBD02), rst asserted after the first ack -> req=0 during reset; state IDLE; ir_wb=0; then a fresh instruction runs normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the Thumb memory-stage control.
package ctrl_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        LIST
    } mem_state_t;

    localparam logic [15:0] NOP_THUMB   = 16'hBF00;

    localparam logic [15:0] MASK_OP4    = 16'hF000;
    localparam logic [15:0] MASK_OP5    = 16'hF800;
    localparam logic [15:0] MASK_OP7    = 16'hFE00;

    localparam logic [15:0] OP_LDST_REG = 16'h5000;
    localparam logic [15:0] OP_LDST_W   = 16'h6000;
    localparam logic [15:0] OP_LDST_B   = 16'h7000;
    localparam logic [15:0] OP_LDST_H   = 16'h8000;
    localparam logic [15:0] OP_LDST_SP  = 16'h9000;
    localparam logic [15:0] OP_LDR_PC   = 16'h4800;
    localparam logic [15:0] OP_PUSH     = 16'hB400;
    localparam logic [15:0] OP_POP      = 16'hBC00;
    localparam logic [15:0] OP_LDM_STM  = 16'hC000;

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_decode.sv
// Combinational decode of a Thumb instruction into its data-memory access attributes.
module mem_decode
    import ctrl_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic        o_is_mem,
    output logic        o_is_list,
    output logic        o_we,
    output mem_size_t   o_size,
    output logic        o_sext,
    output logic [2:0]  o_rt,
    output logic [9:0]  o_rlist
);

    // rlist[7:0] = r0..r7, rlist[8] = LR (PUSH), rlist[9] = PC (POP)
    always_comb begin
        o_is_mem  = 1'b0;
        o_is_list = 1'b0;
        o_we      = 1'b0;
        o_size    = WORD;
        o_sext    = 1'b0;
        o_rt      = i_ir[2:0];
        o_rlist   = 10'd0;

        if ((i_ir & MASK_OP4) == OP_LDST_REG) begin
            o_is_mem = 1'b1;
            unique case (i_ir[11:9])
                3'b000: begin o_we = 1'b1; o_size = WORD; end
                3'b001: begin o_we = 1'b1; o_size = HALF; end
                3'b010: begin o_we = 1'b1; o_size = BYTE; end
                3'b011: begin o_size = BYTE; o_sext = 1'b1; end
                3'b100: begin o_size = WORD; end
                3'b101: begin o_size = HALF; end
                3'b110: begin o_size = BYTE; end
                3'b111: begin o_size = HALF; o_sext = 1'b1; end
            endcase
        end else if ((i_ir & MASK_OP4) == OP_LDST_W) begin
            o_is_mem = 1'b1;
            o_we     = ~i_ir[11];
            o_size   = WORD;
        end else if ((i_ir & MASK_OP4) == OP_LDST_B) begin
            o_is_mem = 1'b1;
            o_we     = ~i_ir[11];
            o_size   = BYTE;
        end else if ((i_ir & MASK_OP4) == OP_LDST_H) begin
            o_is_mem = 1'b1;
            o_we     = ~i_ir[11];
            o_size   = HALF;
        end else if ((i_ir & MASK_OP4) == OP_LDST_SP) begin
            o_is_mem = 1'b1;
            o_we     = ~i_ir[11];
            o_size   = WORD;
            o_rt     = i_ir[10:8];
        end else if ((i_ir & MASK_OP5) == OP_LDR_PC) begin
            o_is_mem = 1'b1;
            o_size   = WORD;
            o_rt     = i_ir[10:8];
        end else if ((i_ir & MASK_OP7) == OP_PUSH) begin
            o_is_mem  = 1'b1;
            o_is_list = 1'b1;
            o_we      = 1'b1;
            o_rlist   = {1'b0, i_ir[8], i_ir[7:0]};
        end else if ((i_ir & MASK_OP7) == OP_POP) begin
            o_is_mem  = 1'b1;
            o_is_list = 1'b1;
            o_rlist   = {i_ir[8], 1'b0, i_ir[7:0]};
        end else if ((i_ir & MASK_OP4) == OP_LDM_STM) begin
            o_is_mem  = 1'b1;
            o_is_list = 1'b1;
            o_we      = ~i_ir[11];
            o_rlist   = {2'b00, i_ir[7:0]};
        end
    end

endmodule

// File: rtl/ctrl_mem.sv
// MEM-stage control: data-memory handshake, LDM/STM/PUSH/POP sequencing, stall and WB IR.
module ctrl_mem
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_ir_mem,
    input  logic        i_stall,
    input  logic        i_dmem_ack,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [1:0]  o_dmem_size,
    output logic        o_dmem_sext,
    output logic [3:0]  o_xfer_reg,
    output logic [3:0]  o_xfer_ofs,
    output logic [3:0]  o_xfer_cnt,
    output logic        o_stall,
    output logic        o_bus_fault,
    output logic [15:0] o_ir_wb
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    mem_state_t         r_state;
    logic [3:0]         r_count;
    logic [9:0]         r_rem;
    logic               r_inflight;
    logic [TIMER_W-1:0] r_timer;
    logic [15:0]        r_ir_wb;

    logic       w_is_mem;
    logic       w_is_list;
    logic       w_we;
    mem_size_t  w_size;
    logic       w_sext;
    logic [2:0] w_rt;
    logic [9:0] w_rlist;

    logic [3:0] w_cnt;
    logic       w_mem_op;
    logic [9:0] w_mask;
    logic [3:0] w_bit;
    logic [3:0] w_xfer_reg;
    logic       w_req_raw;
    logic       w_req;
    logic       w_ack;
    logic       w_final;
    logic       w_done;
    logic       w_timeout;

    mem_decode u_decode (
        .i_ir      (i_ir_mem),
        .o_is_mem  (w_is_mem),
        .o_is_list (w_is_list),
        .o_we      (w_we),
        .o_size    (w_size),
        .o_sext    (w_sext),
        .o_rt      (w_rt),
        .o_rlist   (w_rlist)
    );

    assign w_cnt    = w_is_list ? popcount10(w_rlist) : {3'b000, w_is_mem};
    // An empty register list behaves exactly like a non-memory op.
    assign w_mem_op = w_is_mem & (w_cnt != 4'd0);
    assign w_mask   = (r_state == IDLE) ? w_rlist : r_rem;

    always_comb begin
        w_bit = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (w_mask[i]) begin
                w_bit = 4'(i);
            end
        end
    end

    always_comb begin
        w_xfer_reg = {1'b0, w_rt};
        if (w_is_list) begin
            if (w_bit == 4'd8) begin
                w_xfer_reg = 4'd14;
            end else if (w_bit == 4'd9) begin
                w_xfer_reg = 4'd15;
            end else begin
                w_xfer_reg = w_bit;
            end
        end
    end

    // A transfer already on the bus stays requested; a new one waits for i_stall to drop.
    assign w_req_raw = ~rst & ((r_state == IDLE) ? (w_mem_op & ~i_stall)
                                                 : (r_inflight | ~i_stall));
    assign w_timeout = (TIMEOUT_CYCLES != 0) & (r_state != IDLE) & w_req_raw & ~i_dmem_ack
                     & (r_timer == TIMER_LAST);
    assign w_req     = w_req_raw & ~w_timeout;
    assign w_ack     = w_req & i_dmem_ack;
    assign w_final   = ~w_is_list | (r_count == (w_cnt - 4'd1));
    assign w_done    = w_ack & w_final;

    assign o_dmem_req  = w_req;
    assign o_dmem_we   = w_req & w_we;
    assign o_dmem_size = w_req ? w_size : BYTE;
    assign o_dmem_sext = w_req & w_sext;
    assign o_xfer_reg  = w_xfer_reg;
    assign o_xfer_ofs  = r_count;
    assign o_xfer_cnt  = w_cnt;
    assign o_stall     = w_req & ~w_done;
    assign o_bus_fault = w_timeout;
    assign o_ir_wb     = r_ir_wb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= 4'd0;
            r_rem      <= 10'd0;
            r_inflight <= 1'b0;
            r_timer    <= '0;
            r_ir_wb    <= 16'h0000;
        end else begin
            // An aborted access discards its instruction, so WB sees a bubble.
            if (w_timeout || o_stall) begin
                r_ir_wb <= NOP_THUMB;
            end else if (!i_stall) begin
                r_ir_wb <= i_ir_mem;
            end

            if (TIMEOUT_CYCLES == 0 || w_ack || w_timeout) begin
                r_timer <= '0;
            end else if (w_req) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_timeout || w_done) begin
                r_state    <= IDLE;
                r_count    <= 4'd0;
                r_rem      <= 10'd0;
                r_inflight <= 1'b0;
            end else if (w_ack) begin
                r_state    <= LIST;
                r_count    <= r_count + 4'd1;
                r_rem      <= w_mask & (w_mask - 10'd1);
                r_inflight <= 1'b0;
            end else if (w_req) begin
                if (r_state == IDLE) begin
                    r_state <= w_is_list ? LIST : ACCESS;
                end
                r_rem      <= w_mask;
                r_inflight <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_mem.sv
// Directed bench for ctrl_mem: decode table plus multi-cycle handshake, list, timeout and reset cases.
module tb_ctrl_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        stall_in;
    logic        ack;

    logic        req, we, sext, stall, fault;
    logic [1:0]  size;
    logic [3:0]  xreg, xofs, xcnt;
    logic [15:0] ir_wb;

    logic        req_t, we_t, sext_t, stall_t, fault_t;
    logic [1:0]  size_t;
    logic [3:0]  xreg_t, xofs_t, xcnt_t;
    logic [15:0] ir_wb_t;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_mem dut (
        .clk         (clk),
        .rst         (rst),
        .i_ir_mem    (ir),
        .i_stall     (stall_in),
        .i_dmem_ack  (ack),
        .o_dmem_req  (req),
        .o_dmem_we   (we),
        .o_dmem_size (size),
        .o_dmem_sext (sext),
        .o_xfer_reg  (xreg),
        .o_xfer_ofs  (xofs),
        .o_xfer_cnt  (xcnt),
        .o_stall     (stall),
        .o_bus_fault (fault),
        .o_ir_wb     (ir_wb)
    );

    ctrl_mem #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk         (clk),
        .rst         (rst),
        .i_ir_mem    (ir),
        .i_stall     (stall_in),
        .i_dmem_ack  (ack),
        .o_dmem_req  (req_t),
        .o_dmem_we   (we_t),
        .o_dmem_size (size_t),
        .o_dmem_sext (sext_t),
        .o_xfer_reg  (xreg_t),
        .o_xfer_ofs  (xofs_t),
        .o_xfer_cnt  (xcnt_t),
        .o_stall     (stall_t),
        .o_bus_fault (fault_t),
        .o_ir_wb     (ir_wb_t)
    );

    typedef struct {
        logic [15:0] ir;
        logic        st;
        logic        req;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [3:0]  rg;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc_drive(input logic [15:0] i, input logic s, input logic a);
        @(negedge clk);
        ir       = i;
        stall_in = s;
        ack      = a;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_wb;

    initial begin
        // ir, i_stall, req, we, size, sext, reg, cnt (ack=1 throughout)
        vecs[0]  = '{16'h5442, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd2,  4'd1}; // STRB reg
        vecs[1]  = '{16'h684B, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd3,  4'd1}; // LDR imm
        vecs[2]  = '{16'h5E8D, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 4'd5,  4'd1}; // LDRSH
        vecs[3]  = '{16'h5607, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 4'd7,  4'd1}; // LDRSB
        vecs[4]  = '{16'h8051, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 4'd1,  4'd1}; // STRH imm
        vecs[5]  = '{16'h78F4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd4,  4'd1}; // LDRB imm
        vecs[6]  = '{16'h9602, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 4'd6,  4'd1}; // STR sp
        vecs[7]  = '{16'h4A04, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd2,  4'd1}; // LDR pc
        vecs[8]  = '{16'hB500, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 4'd14, 4'd1}; // PUSH {LR}
        vecs[9]  = '{16'hBD00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd15, 4'd1}; // POP {PC}
        vecs[10] = '{16'hC920, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd5,  4'd1}; // LDM {r5}
        vecs[11] = '{16'hC800, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0,  4'd0}; // LDM {}
        vecs[12] = '{16'h1C08, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0,  4'd0}; // ADDS
        vecs[13] = '{16'h684B, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0,  4'd1}; // stalled in IDLE
        vecs[14] = '{16'h4400, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0,  4'd0}; // ADD hi

        rst = 1'b1; ir = 16'h684B; stall_in = 1'b0; ack = 1'b0;
        cyc_drive(16'h684B, 1'b0, 1'b0);
        check("reset req", {31'd0, req}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        after_edge();
        check("reset ir_wb", {16'd0, ir_wb}, 32'h0000);
        check("reset fault", {31'd0, fault_t}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ir  = 16'h1C08;
        after_edge();
        exp_wb = 16'h1C08;

        for (int i = 0; i < 15; i++) begin
            cyc_drive(vecs[i].ir, vecs[i].st, 1'b1);
            check($sformatf("v%0d req", i), {31'd0, req}, {31'd0, vecs[i].req});
            check($sformatf("v%0d stall", i), {31'd0, stall}, 32'd0);
            check($sformatf("v%0d cnt", i), {28'd0, xcnt}, {28'd0, vecs[i].cnt});
            if (vecs[i].req) begin
                check($sformatf("v%0d we", i), {31'd0, we}, {31'd0, vecs[i].we});
                check($sformatf("v%0d size", i), {30'd0, size}, {30'd0, vecs[i].size});
                check($sformatf("v%0d sext", i), {31'd0, sext}, {31'd0, vecs[i].sext});
                check($sformatf("v%0d reg", i), {28'd0, xreg}, {28'd0, vecs[i].rg});
                check($sformatf("v%0d ofs", i), {28'd0, xofs}, 32'd0);
            end
            if (!vecs[i].st) exp_wb = vecs[i].ir;
            after_edge();
            check($sformatf("v%0d ir_wb", i), {16'd0, ir_wb}, {16'd0, exp_wb});
        end

        // LDR r3,[r1,#4] with ack on the third cycle
        cyc_drive(16'h684B, 1'b0, 1'b0);
        check("ldr c1 req", {31'd0, req}, 32'd1);
        check("ldr c1 size", {30'd0, size}, 32'd2);
        check("ldr c1 reg", {28'd0, xreg}, 32'd3);
        check("ldr c1 stall", {31'd0, stall}, 32'd1);
        after_edge();
        check("ldr c1 ir_wb", {16'd0, ir_wb}, 32'hBF00);
        cyc_drive(16'h684B, 1'b0, 1'b0);
        check("ldr c2 stall", {31'd0, stall}, 32'd1);
        after_edge();
        check("ldr c2 ir_wb", {16'd0, ir_wb}, 32'hBF00);
        cyc_drive(16'h684B, 1'b0, 1'b1);
        check("ldr c3 req", {31'd0, req}, 32'd1);
        check("ldr c3 stall", {31'd0, stall}, 32'd0);
        after_edge();
        check("ldr c3 ir_wb", {16'd0, ir_wb}, 32'h684B);

        // PUSH {r0,r4,LR}, zero-wait memory
        cyc_drive(16'hB511, 1'b0, 1'b1);
        check("push t0 reg", {28'd0, xreg}, 32'd0);
        check("push t0 ofs", {28'd0, xofs}, 32'd0);
        check("push cnt", {28'd0, xcnt}, 32'd3);
        check("push t0 we", {31'd0, we}, 32'd1);
        check("push t0 stall", {31'd0, stall}, 32'd1);
        after_edge();
        check("push t0 ir_wb", {16'd0, ir_wb}, 32'hBF00);
        cyc_drive(16'hB511, 1'b0, 1'b1);
        check("push t1 reg", {28'd0, xreg}, 32'd4);
        check("push t1 ofs", {28'd0, xofs}, 32'd1);
        check("push t1 stall", {31'd0, stall}, 32'd1);
        after_edge();
        cyc_drive(16'hB511, 1'b0, 1'b1);
        check("push t2 reg", {28'd0, xreg}, 32'd14);
        check("push t2 ofs", {28'd0, xofs}, 32'd2);
        check("push t2 stall", {31'd0, stall}, 32'd0);
        after_edge();
        check("push ir_wb", {16'd0, ir_wb}, 32'hB511);

        // LDRSH with no ack: the TIMEOUT_CYCLES=4 instance aborts in cycle 4
        for (int c = 1; c <= 3; c++) begin
            cyc_drive(16'h5E8D, 1'b0, 1'b0);
            check($sformatf("to c%0d req", c), {31'd0, req_t}, 32'd1);
            check($sformatf("to c%0d fault", c), {31'd0, fault_t}, 32'd0);
            after_edge();
        end
        cyc_drive(16'h5E8D, 1'b0, 1'b0);
        check("to c4 fault", {31'd0, fault_t}, 32'd1);
        check("to c4 req", {31'd0, req_t}, 32'd0);
        check("to c4 stall", {31'd0, stall_t}, 32'd0);
        check("noto c4 req", {31'd0, req}, 32'd1);
        check("noto c4 fault", {31'd0, fault}, 32'd0);
        after_edge();
        check("to ir_wb", {16'd0, ir_wb_t}, 32'hBF00);
        cyc_drive(16'h5E8D, 1'b0, 1'b1);
        check("to c5 fault", {31'd0, fault_t}, 32'd0);
        check("noto c5 stall", {31'd0, stall}, 32'd0);
        after_edge();
        check("noto ir_wb", {16'd0, ir_wb}, 32'h5E8D);

        // POP {r1,PC}, reset after the first ack
        cyc_drive(16'hBD02, 1'b0, 1'b1);
        check("pop t0 reg", {28'd0, xreg}, 32'd1);
        check("pop cnt", {28'd0, xcnt}, 32'd2);
        check("pop t0 stall", {31'd0, stall}, 32'd1);
        after_edge();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("pop rst req", {31'd0, req}, 32'd0);
        check("pop rst stall", {31'd0, stall}, 32'd0);
        after_edge();
        check("pop rst ir_wb", {16'd0, ir_wb}, 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("pop2 t0 reg", {28'd0, xreg}, 32'd1);
        check("pop2 t0 ofs", {28'd0, xofs}, 32'd0);
        after_edge();
        check("pop2 t0 ir_wb", {16'd0, ir_wb}, 32'hBF00);
        cyc_drive(16'hBD02, 1'b1, 1'b0);
        check("pop2 held req", {31'd0, req}, 32'd0);
        after_edge();
        check("pop2 held ir_wb", {16'd0, ir_wb}, 32'hBF00);
        cyc_drive(16'hBD02, 1'b0, 1'b1);
        check("pop2 t1 req", {31'd0, req}, 32'd1);
        check("pop2 t1 reg", {28'd0, xreg}, 32'd15);
        check("pop2 t1 ofs", {28'd0, xofs}, 32'd1);
        check("pop2 t1 stall", {31'd0, stall}, 32'd0);
        after_edge();
        check("pop2 ir_wb", {16'd0, ir_wb}, 32'hBD02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
